// File: rtl/adder_result_fifo_if.sv
// -----------------------------------------------------------------------------
// adder_result_fifo_if
// Handshake bundle between the pipelined adder (producer), the result FIFO and
// the downstream consumer.
//   in_valid  : producer has a sum on in_data
//   in_data   : WIDTH-bit sum, bit WIDTH-1 is the adder carry-out
//   in_ready  : FIFO can accept a word this cycle
//   out_valid : head entry is valid
//   out_data  : head entry
//   out_ready : consumer takes the head this cycle
// Modports: slave = FIFO side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface adder_result_fifo_if #(
    parameter int WIDTH = 33
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/adder_result_fifo.sv
// -----------------------------------------------------------------------------
// adder_result_fifo
// Small synchronous FIFO that buffers adder sums for a slower consumer, with a
// sticky overflow flag and a saturating count of carry-out words for debug.
// Ports:
//   clock     : single clock, rising edge
//   reset     : asynchronous, active-high; clears pointers, count, flags, storage
//   clear     : synchronous clear of overflow and carry_cnt only
//   bus       : valid/ready handshake bundle (slave side)
//   count     : occupancy 0..DEPTH
//   overflow  : sticky, set when a word is presented while full
//   carry_cnt : saturating count of accepted words with the carry bit set
// -----------------------------------------------------------------------------
module adder_result_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    adder_result_fifo_if.slave       bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CW-1:0]            carry_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CARRY_MAX = '1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic [CW-1:0]    r_carry_cnt;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // Ready/valid come only from the registered count, so there is no
    // combinational path from in_valid/out_ready to in_ready/out_valid.
    assign w_in_ready  = (r_count != FULL_CNT);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid  && w_in_ready;
    assign w_pop       = bus.out_ready && w_out_valid;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_mem[r_rptr];
    assign count         = r_count;
    assign overflow      = r_overflow;
    assign carry_cnt     = r_carry_cnt;

    // Storage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= bus.in_data;
        end
    end

    // Pointers wrap naturally; full/empty come from r_count, so pointer
    // equality never needs to be disambiguated.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Debug flags; clear wins over a same-cycle set or increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_carry_cnt <= '0;
        end else if (clear) begin
            r_overflow  <= 1'b0;
            r_carry_cnt <= '0;
        end else begin
            if (bus.in_valid && !w_in_ready) begin
                r_overflow <= 1'b1;
            end
            if (w_push && bus.in_data[WIDTH-1] && (r_carry_cnt != CARRY_MAX)) begin
                r_carry_cnt <= r_carry_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_adder_result_fifo.sv
module tb_adder_result_fifo;
    localparam int WIDTH = 33;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          clear;
    logic [2:0]    count;
    logic          overflow;
    logic [CW-1:0] carry_cnt;

    adder_result_fifo_if #(.WIDTH(WIDTH)) bus ();

    adder_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .bus       (bus),
        .count     (count),
        .overflow  (overflow),
        .carry_cnt (carry_cnt)
    );

    always #5 clock = ~clock;

    // Scoreboard and reference model state
    logic [WIDTH-1:0] exp_q [$];
    int   m_cnt;
    logic m_ovf;
    int   m_carry;
    int   n_checks;
    int   n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_carry = 0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // advance the model, then move to 1 time unit after the next edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic c);
        logic push;
        logic pop;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        clear         = c;
        chk("count",     64'(count),         64'(m_cnt));
        chk("in_ready",  64'(bus.in_ready),  64'(m_cnt != DEPTH));
        chk("out_valid", 64'(bus.out_valid), 64'(m_cnt != 0));
        chk("overflow",  64'(overflow),      64'(m_ovf));
        chk("carry_cnt", 64'(carry_cnt),     64'(m_carry));
        push = v && (m_cnt != DEPTH);
        pop  = r && (m_cnt != 0);
        if (pop) begin
            chk("out_data", 64'(bus.out_data), 64'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        if (push) exp_q.push_back(d);
        if (c) begin
            m_ovf   = 1'b0;
            m_carry = 0;
        end else begin
            if (v && (m_cnt == DEPTH)) m_ovf = 1'b1;
            if (push && d[WIDTH-1] && (m_carry != 255)) m_carry++;
        end
        m_cnt = m_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
        @(posedge clock);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clear         = 1'b0;
    endtask

    logic [WIDTH-1:0] wrap_data [10];

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        model_reset();
        reset         = 1'b1;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        chk("rst_count",     64'(count),         64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_overflow",  64'(overflow),      64'd0);
        chk("rst_carry",     64'(carry_cnt),     64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        reset = 1'b0;

        // Asynchronous reset mid-cycle with two entries stored
        step(1'b1, 33'h1_00000005, 1'b0, 1'b0);
        step(1'b1, 33'h1_00000006, 1'b0, 1'b0);
        chk("pre_rst_count", 64'(count),     64'd2);
        chk("pre_rst_carry", 64'(carry_cnt), 64'd2);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_count",     64'(count),         64'd0);
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("arst_carry",     64'(carry_cnt),     64'd0);
        chk("arst_out_data",  64'(bus.out_data),  64'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Push four words with the consumer stalled
        step(1'b1, 33'd7100, 1'b0, 1'b0);
        step(1'b1, 33'd7100, 1'b0, 1'b0);
        step(1'b1, 33'd9253, 1'b0, 1'b0);
        step(1'b1, 33'd1,    1'b0, 1'b0);
        chk("full_count",    64'(count),        64'd4);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);

        // Overflow while full, clear, clear priority, full with pop
        step(1'b1, 33'd300, 1'b0, 1'b0);
        chk("ovf_set", 64'(overflow), 64'd1);
        step(1'b0, 33'd0,   1'b0, 1'b1);
        chk("ovf_clr", 64'(overflow), 64'd0);
        step(1'b1, 33'd301, 1'b0, 1'b1);
        chk("ovf_clr_prio", 64'(overflow), 64'd0);
        step(1'b1, 33'd555, 1'b1, 1'b0);
        chk("ovf_full_pop", 64'(overflow), 64'd1);
        chk("count_full_pop", 64'(count), 64'd3);

        // Drain remaining words
        step(1'b0, 33'd0, 1'b1, 1'b0);
        step(1'b0, 33'd0, 1'b1, 1'b0);
        step(1'b0, 33'd0, 1'b1, 1'b0);
        step(1'b0, 33'd0, 1'b1, 1'b0);
        chk("empty_out_valid", 64'(bus.out_valid), 64'd0);

        // Carry counter
        step(1'b0, 33'd0, 1'b0, 1'b1);
        step(1'b1, 33'h1_0FFFFFFE, 1'b1, 1'b0);
        step(1'b1, 33'h0_00005D1C, 1'b1, 1'b0);
        step(1'b1, 33'h1_FFFE0000, 1'b1, 1'b0);
        chk("carry_two", 64'(carry_cnt), 64'd2);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, {1'b1, 32'($urandom)}, 1'b1, 1'b0);
        end
        chk("carry_sat", 64'(carry_cnt), 64'd255);
        step(1'b0, 33'd0, 1'b1, 1'b1);
        chk("carry_clr", 64'(carry_cnt), 64'd0);
        step(1'b0, 33'd0, 1'b1, 1'b0);
        step(1'b0, 33'd0, 1'b1, 1'b0);

        // Streaming at full rate
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 33'(i), 1'b1, 1'b0);
        end
        chk("stream_count", 64'(count),    64'd1);
        chk("stream_ovf",   64'(overflow), 64'd0);
        step(1'b0, 33'd0, 1'b1, 1'b0);

        // Pointer wrap with random gaps
        for (int i = 0; i < 10; i++) wrap_data[i] = 33'(1000 + i);
        wrap_data[5] = 33'(32'hFFFFFFF1) + 33'(32'h0FFFFFEF);
        begin
            int idx;
            idx = 0;
            for (int n = 0; n < 200 && idx < 10; n++) begin
                if ($urandom_range(0, 2) == 0) begin
                    step(1'b0, 33'd0, 1'($urandom_range(0, 1)), 1'b0);
                end else begin
                    if (m_cnt != DEPTH) begin
                        step(1'b1, wrap_data[idx], 1'($urandom_range(0, 1)), 1'b0);
                        idx++;
                    end else begin
                        step(1'b0, 33'd0, 1'b1, 1'b0);
                    end
                end
            end
            chk("wrap_all_pushed", 64'(idx), 64'd10);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 33'd0, 1'b1, 1'b0);
        chk("wrap_drained", 64'(count), 64'd0);
        chk("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_result_fifo.md
# adder_result_fifo

Buffers the 33-bit sums produced by the two-stage pipelined adder so a slower downstream consumer can drain them under a valid/ready handshake. Sits directly downstream of the adder: the adder's `out_sum` feeds `in_data`, and a valid bit delayed two cycles alongside the operands feeds `in_valid`. It also keeps a sticky overflow flag and a saturating count of carry-out results for debug.

## Interface
- `WIDTH`, 33: data width. Bit `WIDTH-1` is the adder carry-out.
- `DEPTH`, 4: number of entries. Must be a power of 2 and at least 2.
- `CW`, 8: width of `carry_cnt`.
- `clock`  in  1  Single clock. All state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-high reset.
- `clear`  in  1  Synchronous clear of `overflow` and `carry_cnt` only. Does not touch FIFO contents.
- `in_valid`  in  1  Producer has a sum on `in_data`.
- `in_data`  in  WIDTH  Sum from the adder.
- `in_ready`  out  1  FIFO can accept a word this cycle (`count != DEPTH`).
- `out_valid`  out  1  Head entry is valid (`count != 0`).
- `out_data`  out  WIDTH  Head entry. Registered storage output, not combinational from `in_data`.
- `out_ready`  in  1  Consumer takes the head this cycle.
- `count`  out  log2(DEPTH)+1  Current occupancy, 0..DEPTH.
- `overflow`  out  1  Sticky. Set when `in_valid && !in_ready`.
- `carry_cnt`  out  CW  Saturating count of accepted words with `in_data[WIDTH-1]=1`.

## Operation
- **Push:** happens when `in_valid && in_ready`. Writes `in_data` at the write pointer and advances the pointer modulo DEPTH.
- **Pop:** happens when `out_valid && out_ready`. Advances the read pointer modulo DEPTH. `out_data` then shows the next entry.
- **Pointers:** read and write pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived from `count`, not from pointer equality.
- **Count update:**
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Unchanged when neither happens.
- **Simultaneous push and pop when `count` is between 1 and DEPTH-1:** both take effect and `count` is unchanged.
- **Full (`count=DEPTH`):** `in_ready=0`, so no push occurs even if a pop happens in the same cycle. Any `in_valid` presented while full is dropped and sets `overflow`. Stored data is never corrupted.
- **Empty (`count=0`):**
  - `out_valid=0`, and `out_ready` is ignored.
  - `out_data` holds the value at the read pointer, which is a don't-care.
  - No fall-through: a word pushed into an empty FIFO first appears on `out_valid` in the next cycle.
- **Carry counter:** `carry_cnt` increments on each push whose `in_data[WIDTH-1]=1`. It holds at 2^CW-1 once saturated.
- **Clear:** `clear` zeroes `overflow` and `carry_cnt`. `clear` has priority over any set or increment in the same cycle.
- **Data width:** data is stored unmodified. No truncation or sign handling; all WIDTH bits pass through bit-exact.

## Timing
- **Reset values:** while `reset` is high, asynchronously:
  - both pointers = 0, `count=0`
  - `out_valid=0`, `in_ready=1`
  - `overflow=0`, `carry_cnt=0`
  - `out_data=0`, with storage cleared to 0
- **Reset mid-operation:** all entries are discarded immediately. No handshake completes in a cycle where `reset` is high.
- **Write-to-read latency:** 1 cycle. A push at edge N gives `out_valid=1` with that data after edge N, if the FIFO was empty.
- **Ready/valid timing:** `in_ready` and `out_valid` depend only on registered `count`. There are no combinational paths from `in_valid`/`out_ready` to `in_ready`/`out_valid`.
- **Overflow flag:** `overflow` is set at the edge that sees the dropped word and is visible the following cycle.
- **Throughput:** one push and one pop per cycle are sustainable at any occupancy from 1 to DEPTH-1.

## Test plan
- **Reset:** assert `reset` mid-cycle with 2 entries stored. Required: `count`, `out_valid` and `carry_cnt` go to 0 immediately without a clock edge, and `in_ready=1`.
- **Push then drain:**
  - Hold `out_ready=0` and push 7100, 7100, 9253, 1. Required: `count` reads 1,2,3,4, and `in_ready=0` after the 4th push.
  - Then set `out_ready=1`. Required: `out_data` reads 7100, 7100, 9253, 1 on consecutive cycles, then `out_valid=0`.
- **Overflow while full:**
  - With the FIFO full, present `in_valid` with 300. Required: the word is dropped, `overflow=1` on the next cycle, and the contents are unchanged.
  - Pulse `clear`. Required: `overflow=0`.
- **Carry count:**
  - Push 0x1_0FFFFFFE (carry set), 0x0_00005D1C, then 0x1_FFFE0000. Required: `carry_cnt=2`.
  - Push 300 more carry words. Required: `carry_cnt` saturates at 255.
- **Streaming:** run with `in_valid=1` and `out_ready=1` every cycle for 20 words starting at 0 and incrementing by 1. Required:
  - After the first word, `count` stays at 1.
  - `out_data` matches the input order with 1-cycle latency.
  - No drops occur.
- **Pointer wrap:** run 10 push/pop cycles with random gaps, crossing the DEPTH boundary at least twice. Required: output order is preserved, including the values 0xFFFFFFF1+0x0FFFFFEF=0x1_0FFFFFE0.
